program_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the CPU datapath's flash write port. It accepts a byte stream through a valid/ready handshake: a 32-bit little-endian word count, then that many 32-bit little-endian instruction/data words. It drives flash_en/flash_addr/flash_data to write each word into memory, and holds the CPU idle until the image is complete.

---
 rtl/loader_pkg.sv | 17 +
 rtl/byte_packer.sv | 56 +++++
 rtl/program_loader.sv | 148 ++++++++++++++
 tb/tb_program_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and word geometry for the program loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Index of the byte that completes a word in the packer.
    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word assembler shared by header and payload
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_take_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] sr_q, sr_d;

    // Place each accepted byte at its little-endian lane; the 4th byte is never stored.
    always_comb begin
        idx_d = idx_q;
        sr_d  = sr_q;
        if (clear_i) begin
            idx_d = 2'd0;
            sr_d  = 24'd0;
        end else if (byte_take_i) begin
            if (idx_q == LAST_BYTE_IDX) begin
                idx_d = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
                case (idx_q)
                    2'd0:    sr_d[7:0]   = byte_data_i;
                    2'd1:    sr_d[15:8]  = byte_data_i;
                    2'd2:    sr_d[23:16] = byte_data_i;
                    default: sr_d        = sr_q;
                endcase
            end
        end
    end

    // Byte index and partial-word register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q <= 2'd0;
            sr_q  <= 24'd0;
        end else begin
            idx_q <= idx_d;
            sr_q  <= sr_d;
        end
    end

    // The completed word is presented combinationally while the 4th byte is on the bus.
    always_comb begin
        word_valid_o = byte_take_i && !clear_i && (idx_q == LAST_BYTE_IDX);
        word_o       = {byte_data_i, sr_q};
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader turning a length-prefixed byte stream into flash writes
module program_loader
    import loader_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               MAX_WORDS = 1024,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             flash_en,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] word_count
);

    loader_state_t    state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] word_count_q, word_count_d;
    logic             flash_en_q, flash_en_d;
    logic [WIDTH-1:0] flash_addr_q, flash_addr_d;
    logic [WIDTH-1:0] flash_data_q, flash_data_d;

    logic             take;
    logic             start_taken;
    logic             pk_valid;
    logic [31:0]      pk_word;
    logic [WIDTH-1:0] rx_word;
    logic [WIDTH-1:0] wc_inc;

    assign take        = byte_valid && byte_ready;
    assign start_taken = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign rx_word     = WIDTH'(pk_word);
    assign wc_inc      = word_count_q + WIDTH'(1);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_taken),
        .byte_take_i  (take),
        .byte_data_i  (byte_data),
        .word_valid_o (pk_valid),
        .word_o       (pk_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: header decides DONE/ERROR/DATA, payload finishes on the N-th word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (pk_valid) begin
                    if (rx_word == '0) begin
                        state_d = DONE;
                    end else if (rx_word > WIDTH'(MAX_WORDS)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (pk_valid && (wc_inc == n_q)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state; the CPU runs only once the image is complete.
    always_comb begin
        busy       = (state_q == LEN) || (state_q == DATA);
        done       = (state_q == DONE);
        error      = (state_q == ERROR);
        cpu_hold   = (state_q != DONE);
        byte_ready = busy;
    end

    // Datapath next values: counters restart on a load, each payload word becomes one write.
    always_comb begin
        n_d          = n_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        flash_en_d   = 1'b0;
        flash_addr_d = flash_addr_q;
        flash_data_d = flash_data_q;
        if (start_taken) begin
            addr_d       = BASE_ADDR;
            word_count_d = '0;
        end else if (pk_valid && state_q == LEN) begin
            n_d = rx_word;
        end else if (pk_valid && state_q == DATA) begin
            flash_en_d   = 1'b1;
            flash_addr_d = addr_q;
            flash_data_d = rx_word;
            addr_d       = addr_q + WIDTH'(BYTES_PER_WORD);
            word_count_d = wc_inc;
        end
    end

    // Datapath registers; reset suppresses any write completed on the reset edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_q          <= '0;
            addr_q       <= BASE_ADDR;
            word_count_q <= '0;
            flash_en_q   <= 1'b0;
            flash_addr_q <= BASE_ADDR;
            flash_data_q <= '0;
        end else begin
            n_q          <= n_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            flash_en_q   <= flash_en_d;
            flash_addr_q <= flash_addr_d;
            flash_data_q <= flash_data_d;
        end
    end

    assign flash_en   = flash_en_q;
    assign flash_addr = flash_addr_q;
    assign flash_data = flash_data_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized bench with a behavioural loader model and per-cycle compare
module tb_program_loader;

    localparam int MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, flash_en, cpu_hold, busy, done, error;
    logic [31:0] flash_addr, flash_data, word_count;

    always #5 clk = ~clk;

    program_loader #(.WIDTH(32), .MAX_WORDS(MAXW), .BASE_ADDR(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .flash_en   (flash_en),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int gap_mode = 0;

    // model: 0 idle, 1 length, 2 data, 3 done, 4 error
    int          m_mode = 0;
    logic [7:0]  m_q[$];
    logic [31:0] m_n, m_wc, m_addr, m_fa, m_fd;
    bit          m_fe;

    logic [31:0] dut_wa[$];
    logic [31:0] dut_wd[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] w;
        if (!rst) begin
            m_mode = 0; m_q.delete(); m_n = 0; m_wc = 0; m_addr = 0;
            m_fa = 0; m_fd = 0; m_fe = 0;
        end else begin
            m_fe = 0;
            if (m_mode == 0 || m_mode == 3 || m_mode == 4) begin
                if (start) begin
                    m_mode = 1; m_q.delete(); m_wc = 0; m_addr = 0;
                end
            end else if (byte_valid) begin
                m_q.push_back(byte_data);
                if (m_q.size() == 4) begin
                    w = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_q.delete();
                    if (m_mode == 1) begin
                        if (w == 0) m_mode = 3;
                        else if (w > MAXW) m_mode = 4;
                        else begin m_n = w; m_mode = 2; end
                    end else begin
                        m_fe = 1; m_fa = m_addr; m_fd = w;
                        m_addr = m_addr + 4; m_wc = m_wc + 1;
                        if (m_wc == m_n) m_mode = 3;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy",       32'(busy),       32'(m_mode == 1 || m_mode == 2));
            chk("byte_ready", 32'(byte_ready), 32'(m_mode == 1 || m_mode == 2));
            chk("done",       32'(done),       32'(m_mode == 3));
            chk("error",      32'(error),      32'(m_mode == 4));
            chk("cpu_hold",   32'(cpu_hold),   32'(m_mode != 3));
            chk("flash_en",   32'(flash_en),   32'(m_fe));
            chk("word_count", word_count,      m_wc);
            if (m_fe) begin
                chk("flash_addr", flash_addr, m_fa);
                chk("flash_data", flash_data, m_fd);
            end
            if (flash_en === 1'b1) begin
                dut_wa.push_back(flash_addr);
                dut_wd.push_back(flash_data);
            end
        end
    end

    task automatic idle_cyc();
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit noise);
        int g;
        int t;
        if (gap_mode == 1) g = 1;
        else if (gap_mode == 2) g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        else g = 0;
        repeat (g) idle_cyc();
        @(negedge clk);
        t = 0;
        while (!byte_ready && t < 50) begin
            byte_valid = 1'b0;
            start = 1'b0;
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            total++; bad++;
            $display("FAIL ready_timeout: byte_ready stayed low at %0t", $time);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        start      = noise && ($urandom_range(0, 5) == 0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit noise, input bit last);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] sh;
            sh = w >> (8 * i);
            send_byte(sh[7:0], noise && !(last && i == 3));
        end
    endtask

    task automatic wait_settle();
        int t;
        t = 0;
        idle_cyc();
        while (!(done || error) && t < 200) begin
            idle_cyc();
            t++;
        end
        chk("settled", 32'(done || error), 32'd1);
    endtask

    task automatic chk_writes(input string nm, input int n,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [31:0] d1);
        chk({nm, "_count"}, 32'(dut_wa.size()), 32'(n));
        if (n >= 1 && dut_wa.size() >= 1) begin
            chk({nm, "_a0"}, dut_wa[0], a0);
            chk({nm, "_d0"}, dut_wd[0], d0);
        end
        if (n >= 2 && dut_wa.size() >= 2) begin
            chk({nm, "_a1"}, dut_wa[1], a1);
            chk({nm, "_d1"}, dut_wd[1], d1);
        end
        dut_wa.delete();
        dut_wd.delete();
    endtask

    initial begin
        // reset held two cycles with a byte offered
        rst = 1'b0; byte_valid = 1'b1; byte_data = 8'hAA;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_flash_en",   32'(flash_en),   32'd0);
        chk("rst_cpu_hold",   32'(cpu_hold),   32'd1);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_flash_addr", flash_addr,      32'h0);
        chk("rst_flash_data", flash_data,      32'h0);
        chk("rst_word_count", word_count,      32'h0);
        rst = 1'b1; byte_valid = 1'b0;

        // basic back-to-back load
        gap_mode = 0;
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        send_word(32'd2, 1'b0, 1'b0);
        send_word(32'h00100513, 1'b0, 1'b0);
        send_word(32'h00200593, 1'b0, 1'b1);
        @(negedge clk);
        chk("basic_last_fe",   32'(flash_en), 32'd1);
        chk("basic_done",      32'(done),     32'd1);
        chk("basic_cpu_hold",  32'(cpu_hold), 32'd0);
        chk("basic_wc",        word_count,    32'd2);
        byte_valid = 1'b0;
        idle_cyc();
        chk_writes("basic", 2, 32'h0, 32'h00100513, 32'h4, 32'h00200593);

        // throttled stream with a long gap mid-word
        gap_mode = 1;
        pulse_start();
        send_word(32'd2, 1'b0, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h05, 1'b0);
        repeat (10) idle_cyc();
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'h00200593, 1'b0, 1'b1);
        wait_settle();
        chk_writes("throttle", 2, 32'h0, 32'h00100513, 32'h4, 32'h00200593);

        // zero-length image
        gap_mode = 0;
        pulse_start();
        send_word(32'd0, 1'b0, 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        idle_cyc();
        chk_writes("zero", 0, 0, 0, 0, 0);

        // oversize header, then bytes offered while in error
        pulse_start();
        send_word(MAXW + 1, 1'b0, 1'b1);
        @(negedge clk);
        chk("over_error",      32'(error),      32'd1);
        chk("over_byte_ready", 32'(byte_ready), 32'd0);
        chk("over_cpu_hold",   32'(cpu_hold),   32'd1);
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        pulse_start();
        chk("err_restart_busy", 32'(busy), 32'd1);
        send_word(32'd1, 1'b0, 1'b0);
        send_word(32'h12345678, 1'b0, 1'b1);
        wait_settle();
        chk_writes("after_err", 1, 32'h0, 32'h12345678, 0, 0);

        // reset after two data bytes
        pulse_start();
        send_word(32'd1, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        @(negedge clk);
        rst = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_wc",   word_count,    32'd0);
        chk("midrst_busy", 32'(busy),     32'd0);
        chk("midrst_fe",   32'(flash_en), 32'd0);

        // reset on the same edge as a completing 4th byte
        pulse_start();
        send_word(32'd1, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; byte_valid = 1'b0;
        chk("rst4_fe", 32'(flash_en), 32'd0);
        chk_writes("rst4", 0, 0, 0, 0, 0);
        pulse_start();
        send_word(32'd1, 1'b0, 1'b0);
        send_word(32'hCAFEF00D, 1'b0, 1'b1);
        wait_settle();
        chk_writes("post_rst", 1, 32'h0, 32'hCAFEF00D, 0, 0);

        // reload from DONE with start noise during data
        gap_mode = 2;
        pulse_start();
        chk("reload_hold", 32'(cpu_hold), 32'd1);
        send_word(32'd1, 1'b1, 1'b0);
        send_word(32'hA5A55A5A, 1'b1, 1'b1);
        wait_settle();
        chk_writes("reload", 1, 32'h0, 32'hA5A55A5A, 0, 0);

        // randomized images against the model
        for (int it = 0; it < 25; it++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 7);
            pulse_start();
            if (kind == 0) begin
                send_word(MAXW + 1 + $urandom_range(0, 5000), 1'b1, 1'b1);
            end else if (kind == 1) begin
                send_word(32'd0, 1'b1, 1'b1);
            end else begin
                n = $urandom_range(1, 6);
                send_word(32'(n), 1'b1, 1'b0);
                for (int k = 0; k < n; k++) begin
                    send_word($urandom, 1'b1, k == n - 1);
                end
            end
            wait_settle();
            repeat ($urandom_range(0, 3)) idle_cyc();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
